e203_exu_wbck_sched: RTL
========================

Name: e203_exu_wbck_sched

Overview:
- Write-back scheduler in the EXU, between the execution sources and the regfile write port.
- Arbitrates three write-back sources onto one registered regfile write interface: untracked ALU results, OITF-tracked ALU results, and long-pipe (LSU/MULDIV) results.
- Enforces in-order retirement of OITF-tracked results against the OITF head pointer.
- Parks out-of-order tracked ALU results in a small hold buffer instead of stalling the ALU.

Parameters:
- DW, 32, write-back data width (XLEN).
- RFIDX_W, 5, register index width.
- ITAG_W, 1, OITF itag width.
- HOLD_DEPTH, 2, hold-buffer entries (power of two, ≥1).
- STARVE_MAX, 4, maximum consecutive lost grants for an untracked ALU result.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- alu_i_valid  in  1  ALU result valid.
- alu_i_ready  out  1  ALU result accepted (output stage or hold buffer).
- alu_i_wdat  in  DW  ALU result data.
- alu_i_rdidx  in  RFIDX_W  ALU destination register.
- alu_i_itag  in  ITAG_W  ALU itag (meaningful when alu_i_longp=1).
- alu_i_longp  in  1  ALU instruction is OITF-tracked.
- lng_i_valid  in  1  long-pipe result valid.
- lng_i_ready  out  1  long-pipe result accepted.
- lng_i_wdat  in  DW  long-pipe result data.
- lng_i_rdidx  in  RFIDX_W  long-pipe destination register.
- lng_i_itag  in  ITAG_W  long-pipe itag.
- oitf_empty  in  1  OITF empty.
- oitf_ret_ptr  in  ITAG_W  itag of the OITF head entry.
- oitf_ret_ena  out  1  retire the OITF head this cycle.
- rf_o_valid  out  1  regfile write valid.
- rf_o_ready  in  1  regfile write accepted.
- rf_o_wdat  out  DW  regfile write data.
- rf_o_rdidx  out  RFIDX_W  regfile write index.
- hold_cnt  out  $clog2(HOLD_DEPTH)+1  occupied hold entries.

Behaviour:
- **Reset:** rf_o_valid=0, rf_o_wdat=0, rf_o_rdidx=0, hold empty (hold_cnt=0), starvation counter=0.
- **Output stage:** one register slot. slot_free = ~rf_o_valid | rf_o_ready.
  - A grant loads the slot when slot_free; the result appears on rf_o_* the next cycle (latency 1).
  - rf_o_valid is held until rf_o_ready. rf_o_* are stable while valid & ~ready.
- **head_ok(t)** = ~oitf_empty & (t == oitf_ret_ptr).
- **Candidates:**
  - H: any valid hold entry with head_ok. Lowest index wins; at most one can match.
  - L: lng_i_valid & head_ok(lng_i_itag).
  - T: alu_i_valid & alu_i_longp & head_ok(alu_i_itag).
  - U: alu_i_valid & ~alu_i_longp.
- **Priority:** H > L > T > U. One grant per cycle, and only when slot_free.
- **Hold push:** alu_i_valid & alu_i_longp & ~head_ok(alu_i_itag) & ~hold_full.
  - Pushes the entry; alu_i_ready=1 regardless of slot_free.
  - If hold is full, alu_i_ready=0.
- **Ready outputs:**
  - alu_i_ready = push | (grant to T or U).
  - lng_i_ready = grant to L. A non-head long-pipe result waits with ready=0.
- **oitf_ret_ena** = grant to H, L or T. It is combinational, so it is 0 in any cycle with no tracked grant, including out of reset.
- **Simultaneous events:**
  - Hold pop (H grant) and hold push in the same cycle are both performed; hold_cnt is unchanged.
  - A push into the last free entry while H pops is allowed.
- **Boundaries:**
  - oitf_empty=1 makes only U eligible.
  - A tracked input while oitf_empty=1 is illegal (assertion). It is pushed and never drained.
- **Reset mid-operation:** the hold contents and the output slot are discarded. The OITF is flushed by the same reset.

Optional Feature:
- Macro: E203_WBCK_SCHED_STARVE_EN.
- Defined:
  - A counter increments each cycle U is pending but not granted, and clears on a U grant or when U is absent.
  - When the count reaches STARVE_MAX, U takes top priority for one grant, then the counter clears.
  - Counter width is $clog2(STARVE_MAX+1).
- Undefined: strict priority H > L > T > U; no counter is instantiated.

Decomposition:
- Shared constants in e203_defines: E203_XLEN, E203_RFIDX_WIDTH, E203_ITAG_WIDTH, and the source-select encodings WBCK_SRC_NONE/HOLD/LNG/ALUT/ALUU.
- Sub-module e203_exu_wbck_hold contains:
  - HOLD_DEPTH entries of {valid, itag, rdidx, wdat};
  - an associative itag match against oitf_ret_ptr;
  - first-free-slot allocation;
  - match-index pop and the hold_cnt counter.

Test Plan:
- oitf_empty=1; ALU untracked x5=0x11 with rf_o_ready=1 → alu_i_ready=1; next cycle rf_o_valid=1, rdidx=5, wdat=0x11; oitf_ret_ena=0.
- oitf_ret_ptr=0, not empty; ALU tracked itag=1 x6=0x22 → pushed, hold_cnt=1, no rf write. Then lng itag=0 x7=0x33 → granted L, oitf_ret_ena=1. Next cycle ret_ptr=1 → H granted, x6=0x22 written, hold_cnt=0.
- Hold full (2 entries, neither head); ALU tracked non-head → alu_i_ready=0 until an H pop. Pop and push in the same cycle → hold_cnt stays 2.
- rf_o_ready=0 for 3 cycles with rf_o_valid=1 → rf_o_* stable, no grants, lng_i_ready=0, oitf_ret_ena=0.
- STARVE_EN, STARVE_MAX=4; U pending while L/H win 4 cycles → 5th cycle grants U. Without the macro, U waits until L/H are absent.
- rst asserted mid-transfer with hold_cnt=2 and rf_o_valid=1 → immediately rf_o_valid=0, hold_cnt=0.

Source files
------------

// File: rtl/e203_exu_wbck_sched_pkg.sv
// Shared widths and write-back source encodings for the EXU write-back scheduler.
package e203_exu_wbck_sched_pkg;

  localparam int unsigned E203_XLEN        = 32;
  localparam int unsigned E203_RFIDX_WIDTH = 5;
  localparam int unsigned E203_ITAG_WIDTH  = 1;

  typedef enum logic [2:0] {
    WBCK_SRC_NONE = 3'd0,
    WBCK_SRC_HOLD = 3'd1,
    WBCK_SRC_LNG  = 3'd2,
    WBCK_SRC_ALUT = 3'd3,
    WBCK_SRC_ALUU = 3'd4
  } wbck_src_e;

endpackage

// File: rtl/e203_exu_wbck_hold.sv
// Hold buffer for OITF-tracked ALU results that arrive before their itag reaches the OITF head.
module e203_exu_wbck_hold
  import e203_exu_wbck_sched_pkg::*;
#(
  parameter int unsigned DW      = E203_XLEN,
  parameter int unsigned RFIDX_W = E203_RFIDX_WIDTH,
  parameter int unsigned ITAG_W  = E203_ITAG_WIDTH,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_match_en,
  input  logic [ITAG_W-1:0]         i_ret_ptr,
  input  logic                      i_push,
  input  logic [ITAG_W-1:0]         i_push_itag,
  input  logic [RFIDX_W-1:0]        i_push_rdidx,
  input  logic [DW-1:0]             i_push_wdat,
  input  logic                      i_pop,
  output logic                      o_hit_c,
  output logic [RFIDX_W-1:0]        o_hit_rdidx_c,
  output logic [DW-1:0]             o_hit_wdat_c,
  output logic                      o_full_c,
  output logic [$clog2(DEPTH):0]    o_cnt
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]   r_vld;
  logic [ITAG_W-1:0]  r_itag  [DEPTH];
  logic [RFIDX_W-1:0] r_rdidx [DEPTH];
  logic [DW-1:0]      r_wdat  [DEPTH];
  logic [CNT_W-1:0]   r_cnt;

  logic               w_hit;
  logic               w_free;
  logic [IDX_W-1:0]   w_hit_idx;
  logic [IDX_W-1:0]   w_free_idx;
  logic [IDX_W-1:0]   w_push_idx;

  // Associative head match and first-free search; descending scan leaves the lowest index.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (r_vld[i] && i_match_en && (r_itag[i] == i_ret_ptr)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
      if (!r_vld[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  // When full, a push can only land in the entry being popped this cycle.
  assign w_push_idx    = w_free ? w_free_idx : w_hit_idx;
  assign o_hit_c       = w_hit;
  assign o_hit_rdidx_c = r_rdidx[w_hit_idx];
  assign o_hit_wdat_c  = r_wdat[w_hit_idx];
  assign o_full_c      = &r_vld;
  assign o_cnt         = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_itag[i]  <= '0;
        r_rdidx[i] <= '0;
        r_wdat[i]  <= '0;
      end
    end else begin
      if (i_pop) begin
        r_vld[w_hit_idx] <= 1'b0;
      end
      if (i_push) begin
        r_vld[w_push_idx]   <= 1'b1;
        r_itag[w_push_idx]  <= i_push_itag;
        r_rdidx[w_push_idx] <= i_push_rdidx;
        r_wdat[w_push_idx]  <= i_push_wdat;
      end
      r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

endmodule

// File: rtl/e203_exu_wbck_sched.sv
// EXU write-back scheduler: hold > long-pipe > tracked ALU > untracked ALU onto one registered RF port.
// Optional untracked-ALU anti-starvation under E203_WBCK_SCHED_STARVE_EN.
module e203_exu_wbck_sched
  import e203_exu_wbck_sched_pkg::*;
#(
  parameter int unsigned DW         = E203_XLEN,
  parameter int unsigned RFIDX_W    = E203_RFIDX_WIDTH,
  parameter int unsigned ITAG_W     = E203_ITAG_WIDTH,
  parameter int unsigned HOLD_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_i_valid,
  output logic                          alu_i_ready,
  input  logic [DW-1:0]                 alu_i_wdat,
  input  logic [RFIDX_W-1:0]            alu_i_rdidx,
  input  logic [ITAG_W-1:0]             alu_i_itag,
  input  logic                          alu_i_longp,
  input  logic                          lng_i_valid,
  output logic                          lng_i_ready,
  input  logic [DW-1:0]                 lng_i_wdat,
  input  logic [RFIDX_W-1:0]            lng_i_rdidx,
  input  logic [ITAG_W-1:0]             lng_i_itag,
  input  logic                          oitf_empty,
  input  logic [ITAG_W-1:0]             oitf_ret_ptr,
  output logic                          oitf_ret_ena,
  output logic                          rf_o_valid,
  input  logic                          rf_o_ready,
  output logic [DW-1:0]                 rf_o_wdat,
  output logic [RFIDX_W-1:0]            rf_o_rdidx,
  output logic [$clog2(HOLD_DEPTH):0]   hold_cnt
);

  logic               r_valid;
  logic [DW-1:0]      r_wdat;
  logic [RFIDX_W-1:0] r_rdidx;

  wbck_src_e          w_src;
  logic               w_slot_free;
  logic               w_alu_head_ok;
  logic               w_lng_head_ok;
  logic               w_cand_h;
  logic               w_cand_l;
  logic               w_cand_t;
  logic               w_cand_u;
  logic               w_u_urgent;
  logic               w_hold_full;
  logic               w_hold_pop;
  logic               w_push;
  logic [RFIDX_W-1:0] w_hold_rdidx;
  logic [DW-1:0]      w_hold_wdat;
  logic [RFIDX_W-1:0] w_rdidx;
  logic [DW-1:0]      w_wdat;

  assign w_slot_free   = ~r_valid | rf_o_ready;
  assign w_alu_head_ok = ~oitf_empty & (alu_i_itag == oitf_ret_ptr);
  assign w_lng_head_ok = ~oitf_empty & (lng_i_itag == oitf_ret_ptr);
  assign w_cand_l      = lng_i_valid & w_lng_head_ok;
  assign w_cand_t      = alu_i_valid & alu_i_longp & w_alu_head_ok;
  assign w_cand_u      = alu_i_valid & ~alu_i_longp;

  e203_exu_wbck_hold #(
    .DW      (DW),
    .RFIDX_W (RFIDX_W),
    .ITAG_W  (ITAG_W),
    .DEPTH   (HOLD_DEPTH)
  ) u_hold (
    .clk           (clk),
    .rst           (rst),
    .i_match_en    (~oitf_empty),
    .i_ret_ptr     (oitf_ret_ptr),
    .i_push        (w_push),
    .i_push_itag   (alu_i_itag),
    .i_push_rdidx  (alu_i_rdidx),
    .i_push_wdat   (alu_i_wdat),
    .i_pop         (w_hold_pop),
    .o_hit_c       (w_cand_h),
    .o_hit_rdidx_c (w_hold_rdidx),
    .o_hit_wdat_c  (w_hold_wdat),
    .o_full_c      (w_hold_full),
    .o_cnt         (hold_cnt)
  );

`ifdef E203_WBCK_SCHED_STARVE_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0] r_starve;

  assign w_u_urgent = (r_starve == STARVE_W'(STARVE_MAX));

  // Counts consecutive lost grants of a pending untracked result; saturates while the slot stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_cand_u && (w_src != WBCK_SRC_ALUU)) begin
      if (!w_u_urgent) begin
        r_starve <= r_starve + STARVE_W'(1);
      end
    end else begin
      r_starve <= '0;
    end
  end
`else
  assign w_u_urgent = 1'b0;
`endif

  always_comb begin
    w_src = WBCK_SRC_NONE;
    if (w_slot_free) begin
      if (w_u_urgent && w_cand_u) w_src = WBCK_SRC_ALUU;
      else if (w_cand_h)          w_src = WBCK_SRC_HOLD;
      else if (w_cand_l)          w_src = WBCK_SRC_LNG;
      else if (w_cand_t)          w_src = WBCK_SRC_ALUT;
      else if (w_cand_u)          w_src = WBCK_SRC_ALUU;
    end
  end

  always_comb begin
    w_wdat  = '0;
    w_rdidx = '0;
    case (w_src)
      WBCK_SRC_HOLD: begin
        w_wdat  = w_hold_wdat;
        w_rdidx = w_hold_rdidx;
      end
      WBCK_SRC_LNG: begin
        w_wdat  = lng_i_wdat;
        w_rdidx = lng_i_rdidx;
      end
      WBCK_SRC_ALUT, WBCK_SRC_ALUU: begin
        w_wdat  = alu_i_wdat;
        w_rdidx = alu_i_rdidx;
      end
      default: ;
    endcase
  end

  // A hold pop frees an entry in the same cycle, so a full buffer can still accept a push.
  assign w_hold_pop   = (w_src == WBCK_SRC_HOLD);
  assign w_push       = alu_i_valid & alu_i_longp & ~w_alu_head_ok & (~w_hold_full | w_hold_pop);
  assign alu_i_ready  = w_push | (w_src == WBCK_SRC_ALUT) | (w_src == WBCK_SRC_ALUU);
  assign lng_i_ready  = (w_src == WBCK_SRC_LNG);
  assign oitf_ret_ena = (w_src == WBCK_SRC_HOLD) | (w_src == WBCK_SRC_LNG) | (w_src == WBCK_SRC_ALUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_wdat  <= '0;
      r_rdidx <= '0;
    end else if (w_slot_free) begin
      r_valid <= (w_src != WBCK_SRC_NONE);
      if (w_src != WBCK_SRC_NONE) begin
        r_wdat  <= w_wdat;
        r_rdidx <= w_rdidx;
      end
    end
  end

  assign rf_o_valid = r_valid;
  assign rf_o_wdat  = r_wdat;
  assign rf_o_rdidx = r_rdidx;

  // Tracked results cannot exist while the OITF is empty; also sanity-check the configuration.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(oitf_empty && ((alu_i_valid && alu_i_longp) || lng_i_valid)))
        else $error("tracked write-back presented while OITF is empty");
      assert ((HOLD_DEPTH >= 1) && ((HOLD_DEPTH & (HOLD_DEPTH - 1)) == 0) && (STARVE_MAX >= 1))
        else $error("illegal write-back scheduler configuration");
    end
  end

endmodule
